// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop rx sync, midpoint-sampling framer, byte FIFO.
// Ports: clk, rst (sync, high), rx, rx_data/rx_valid/rx_ready, frame_err, overrun, busy.
module uart_receiver #(
  parameter int CLK_HZ     = 25000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CPB  = CLK_HZ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] LAST    = CW'(CPB - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BRK
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic          rx_m, rx_s;
  logic          push, fe_d, ov_d;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full, pop, wr_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    sh_d    = sh_q;
    push    = 1'b0;
    fe_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = S_DATA;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          sh_d  = {rx_s, sh_q[7:1]};
          if (idx_q == 3'd7) state_d = S_STOP;
          else idx_d = idx_q + 3'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = S_BRK;
          end
        end
      end
      S_BRK: begin
        cnt_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = rx_valid & rx_ready;
  // When full, a same-cycle pop frees the slot being written.
  assign wr_en = push & (~full | pop);
  assign ov_d  = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= sh_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      frame_err <= fe_d;
      overrun   <= ov_d;
    end
  end

  assign rx_valid = ~empty;
  assign rx_data  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed cases plus random batches.
// A queue of expected bytes models the FIFO; a monitor checks every pop.
module tb_uart_receiver;

  localparam int CPB   = 25000000 / 115200;
  localparam int HALF  = CPB / 2;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int exp_ov = 0;
  logic [7:0] exp_q[$];

  uart_receiver #(
    .CLK_HZ(25000000),
    .BAUD(115200),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .frame_err(frame_err),
    .overrun(overrun),
    .busy(busy)
  );

  always #20 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model: a good frame lands in the FIFO unless it already holds DEPTH
  // unread bytes while the consumer is stalled, in which case it overruns.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    if (stop) begin
      if (!rx_ready && exp_q.size() >= DEPTH) exp_ov++;
      else exp_q.push_back(b);
    end
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop;
    tick(CPB);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (frame_err | overrun) chk("flags_exclusive", frame_err & overrun, 0);
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) chk("unexpected_pop", rx_data, 32'hFFFF_FFFF);
        else chk("pop_data", rx_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1;
    rx = 1'b1;
    rx_ready = 1'b0;
    tick(3);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_fe", frame_err, 0);
    chk("rst_ov", overrun, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick(5);

    // single byte, consumer ready
    rx_ready = 1'b1;
    send_frame(8'h41, 1'b1);
    tick(10);
    chk("t1_drained", exp_q.size(), 0);
    chk("t1_valid", rx_valid, 0);
    chk("t1_fe", fe_cnt, 0);
    chk("t1_ov", ov_cnt, 0);
    chk("t1_busy", busy, 0);

    // short low glitch
    rx = 1'b0;
    tick(50);
    chk("t2_busy_low", busy, 1);
    rx = 1'b1;
    tick(HALF + 20);
    chk("t2_busy_idle", busy, 0);
    chk("t2_valid", rx_valid, 0);
    chk("t2_fe", fe_cnt, 0);

    // bad stop bit followed by a held break
    send_frame(8'h55, 1'b0);
    tick(3000);
    chk("t3_fe", fe_cnt, 1);
    chk("t3_busy_brk", busy, 1);
    chk("t3_valid", rx_valid, 0);
    rx = 1'b1;
    tick(10);
    chk("t3_busy_idle", busy, 0);

    // overrun on the fifth byte while stalled
    rx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1);
      tick(20);
    end
    chk("t4_ov", ov_cnt, exp_ov);
    chk("t4_ov_once", ov_cnt, 1);
    chk("t4_head", rx_data, 8'h01);
    chk("t4_valid", rx_valid, 1);
    rx_ready = 1'b1;
    tick(10);
    chk("t4_drained", exp_q.size(), 0);
    chk("t4_valid_end", rx_valid, 0);

    // reset in the middle of data bit 4 of 0xA5
    begin
      logic [7:0] a5;
      a5 = 8'hA5;
      rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 4; i++) begin
        rx = a5[i];
        tick(CPB);
      end
      rx = a5[4];
      tick(HALF);
    end
    rst = 1'b1;
    rx = 1'b1;
    tick(1);
    chk("t5_valid", rx_valid, 0);
    chk("t5_data", rx_data, 0);
    chk("t5_fe", frame_err, 0);
    chk("t5_ov", overrun, 0);
    chk("t5_busy", busy, 0);
    rst = 1'b0;
    tick(2 * CPB);
    send_frame(8'h3C, 1'b1);
    tick(10);
    chk("t5_drained", exp_q.size(), 0);
    chk("t5_fe_cnt", fe_cnt, 1);
    chk("t5_ov_cnt", ov_cnt, exp_ov);

    // random batches with the consumer stalled, then drained
    for (int b = 0; b < 3; b++) begin
      int n;
      n = $urandom_range(1, 6);
      rx_ready = 1'b0;
      for (int i = 0; i < n; i++) begin
        send_frame(8'($urandom), 1'b1);
        tick($urandom_range(2, 30));
      end
      chk("rnd_ov", ov_cnt, exp_ov);
      chk("rnd_valid", rx_valid, 1);
      rx_ready = 1'b1;
      tick(10);
      chk("rnd_drained", exp_q.size(), 0);
      chk("rnd_valid_end", rx_valid, 0);
    end
    chk("final_fe", fe_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
